// File: rtl/barrel_unrotator_if.sv
// barrel_unrotator_if: handshake and data bundle for the barrel_unrotator block.
// master drives the rotated input beat and the output ready; slave is the unrotator itself.
interface barrel_unrotator_if #(
  parameter int unsigned size      = 64,
  parameter int unsigned datawidth = 8
);
  localparam int unsigned stages = $clog2(size);

  logic [datawidth*size-1:0] inarray;
  logic [stages-1:0]         select;
  logic                      in_valid;
  logic                      in_ready;
  logic [datawidth*size-1:0] outarray;
  logic [stages-1:0]         out_select;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;

  modport master (
    output inarray, select, in_valid, out_ready,
    input  in_ready, outarray, out_select, out_valid, busy
  );

  modport slave (
    input  inarray, select, in_valid, out_ready,
    output in_ready, outarray, out_select, out_valid, busy
  );
endinterface

// File: rtl/barrel_unrotator.sv
// barrel_unrotator: pipelined inverse of the forward barrel shifter.
// out element i = in element (i + select) mod size, one log2 rotation step per stage.
// Optional macro BARREL_UNROTATOR_OUTREG_EN adds one output register after the last stage.
module barrel_unrotator #(
  parameter int unsigned size      = 64,
  parameter int unsigned datawidth = 8
) (
  input logic               clk,
  input logic               rst,
  barrel_unrotator_if.slave bus
);
  localparam int unsigned stages = $clog2(size);
  localparam int unsigned width  = datawidth * size;

  logic [width-1:0]  src_data [stages];
  logic [stages-1:0] src_sel  [stages];
  logic [stages-1:0] src_vld;
  logic [width-1:0]  rot_data [stages];

  logic [width-1:0]  data_q [stages];
  logic [stages-1:0] sel_q  [stages];
  logic [stages-1:0] vld_q;

  logic              adv;
  logic              out_valid;

  for (genvar k = 0; k < stages; k++) begin : g_stage
    localparam int unsigned Shift = datawidth * (2 ** k);
    if (k == 0) begin : g_first
      assign src_data[k] = bus.inarray;
      assign src_sel[k]  = bus.select;
      assign src_vld[k]  = bus.in_valid;
    end else begin : g_next
      assign src_data[k] = data_q[k-1];
      assign src_sel[k]  = sel_q[k-1];
      assign src_vld[k]  = vld_q[k-1];
    end
    // Right-rotate by 2^k elements: element i takes element i + 2^k, wrapping at the top.
    assign rot_data[k] = src_sel[k][k] ?
                         ((src_data[k] >> Shift) | (src_data[k] << (width - Shift))) :
                         src_data[k];
  end

  // Rotation stages: all advance together when the output can move, else all hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < stages; k++) begin
        data_q[k] <= '0;
        sel_q[k]  <= '0;
      end
      vld_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < stages; k++) begin
        data_q[k] <= rot_data[k];
        sel_q[k]  <= src_sel[k];
      end
      vld_q <= src_vld;
    end
  end

`ifdef BARREL_UNROTATOR_OUTREG_EN
  logic [width-1:0]  out_data_q;
  logic [stages-1:0] out_sel_q;
  logic              out_vld_q;

  // Extra output register fed by the last rotation stage under the same advance rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
      out_sel_q  <= '0;
      out_vld_q  <= 1'b0;
    end else if (adv) begin
      out_data_q <= data_q[stages-1];
      out_sel_q  <= sel_q[stages-1];
      out_vld_q  <= vld_q[stages-1];
    end
  end

  assign out_valid      = out_vld_q;
  assign bus.outarray   = out_data_q;
  assign bus.out_select = out_sel_q;
  assign bus.busy       = (|vld_q) | out_vld_q;
`else
  assign out_valid      = vld_q[stages-1];
  assign bus.outarray   = data_q[stages-1];
  assign bus.out_select = sel_q[stages-1];
  assign bus.busy       = |vld_q;
`endif

  // Bubbles are not collapsed: the whole pipe moves only when the output slot frees up.
  assign adv          = !out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_barrel_unrotator.sv
// tb_barrel_unrotator: directed and random checks of barrel_unrotator against a queue model.
module tb_barrel_unrotator;
  localparam int unsigned Size   = 64;
  localparam int unsigned Dw     = 8;
  localparam int unsigned Stages = $clog2(Size);
  localparam int unsigned W      = Size * Dw;
`ifdef BARREL_UNROTATOR_OUTREG_EN
  localparam int unsigned Lat = Stages;
`else
  localparam int unsigned Lat = Stages - 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  barrel_unrotator_if #(.size(Size), .datawidth(Dw)) bus ();

  barrel_unrotator #(.size(Size), .datawidth(Dw)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  logic [W-1:0]      exp_q  [$];
  logic [Stages-1:0] esel_q [$];
  bit                expect_ramp = 1'b0;
  logic [W-1:0]      ramp;

  // Array whose element k is (k - s) mod Size: the ramp as the forward shifter leaves it.
  function automatic logic [W-1:0] fwd_ramp(int s);
    logic [W-1:0] r;
    for (int i = 0; i < Size; i++) r[i*Dw +: Dw] = Dw'((i - s + Size) % Size);
    return r;
  endfunction

  // Reference: out element i = in element (i + s) mod Size.
  function automatic logic [W-1:0] unrot(logic [W-1:0] v, int s);
    logic [W-1:0] r;
    for (int i = 0; i < Size; i++) r[i*Dw +: Dw] = v[((i + s) % Size)*Dw +: Dw];
    return r;
  endfunction

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Settle inputs, score the handshakes of the coming edge, then advance one cycle.
  task automatic tick();
    bit in_fire, out_fire;
    #1;
    if (rst) begin
      exp_q.delete();
      esel_q.delete();
    end else begin
      in_fire  = bus.in_valid && bus.in_ready;
      out_fire = bus.out_valid && bus.out_ready;
      if (out_fire) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("spurious_beat", W'(bus.out_valid), '0);
        end else begin
          check("data", bus.outarray, exp_q.pop_front());
          check("out_select", W'(bus.out_select), W'(esel_q.pop_front()));
          if (expect_ramp) check("ramp", bus.outarray, ramp);
        end
      end
      if (in_fire) begin
        exp_q.push_back(unrot(bus.inarray, int'(bus.select)));
        esel_q.push_back(bus.select);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 50) begin
      tick();
      budget++;
    end
    check("drain_empty", W'(exp_q.size()), '0);
  endtask

  task automatic one_beat(logic [W-1:0] d, int s);
    bus.inarray  = d;
    bus.select   = Stages'(s);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    drain();
  endtask

  initial begin
    logic [W-1:0]      snap_data;
    logic [Stages-1:0] snap_sel;
    logic              snap_vld;
    logic [W-1:0]      rnd;
    int                lat;

    ramp          = fwd_ramp(0);
    rst           = 1'b1;
    bus.inarray   = '0;
    bus.select    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", W'(bus.out_valid), '0);
    check("rst_busy", W'(bus.busy), '0);
    check("rst_outarray", bus.outarray, '0);
    check("rst_out_select", W'(bus.out_select), '0);
    check("rst_in_ready", W'(bus.in_ready), W'(1));

    // Identity with latency measurement.
    expect_ramp  = 1'b1;
    bus.inarray  = fwd_ramp(0);
    bus.select   = '0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", W'(lat), W'(Lat));
    drain();

    one_beat(fwd_ramp(5), 5);
    one_beat(fwd_ramp(Size - 1), Size - 1);

    // Full sweep with a 10-cycle stall in the middle.
    n_out = 0;
    for (int s = 0; s < Size; s++) begin
      bus.inarray  = fwd_ramp(s);
      bus.select   = Stages'(s);
      bus.in_valid = 1'b1;
      if (s == 20) begin
        bus.out_ready = 1'b0;
        #1;
        snap_data = bus.outarray;
        snap_sel  = bus.out_select;
        snap_vld  = bus.out_valid;
        check("stall_valid", W'(snap_vld), W'(1));
        repeat (10) begin
          #1;
          check("stall_in_ready", W'(bus.in_ready), '0);
          check("stall_outarray", bus.outarray, snap_data);
          check("stall_out_select", W'(bus.out_select), W'(snap_sel));
          check("stall_out_valid", W'(bus.out_valid), W'(snap_vld));
          tick();
        end
        bus.out_ready = 1'b1;
      end
      tick();
    end
    drain();
    check("sweep_count", W'(n_out), W'(Size));
    expect_ramp = 1'b0;

    // Reset with three beats in flight.
    for (int j = 0; j < 3; j++) begin
      for (int b = 0; b < W / 32; b++) rnd[b*32 +: 32] = $urandom();
      bus.inarray  = rnd;
      bus.select   = Stages'($urandom_range(0, Size - 1));
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", W'(bus.out_valid), '0);
    check("mid_rst_busy", W'(bus.busy), '0);
    check("mid_rst_outarray", bus.outarray, '0);
    check("mid_rst_in_ready", W'(bus.in_ready), W'(1));
    repeat (12) begin
      check("no_stale", W'(bus.out_valid), '0);
      tick();
    end

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < W / 32; b++) rnd[b*32 +: 32] = $urandom();
      bus.inarray   = rnd;
      bus.select    = Stages'($urandom_range(0, Size - 1));
      bus.in_valid  = ($urandom() % 4) != 0;
      bus.out_ready = ($urandom() % 3) != 0;
      #1;
      check("busy", W'(bus.busy), W'(exp_q.size() != 0));
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
